// File: rtl/vga_pkg.sv
// Shared VGA timing constants, counter/coordinate widths and renderer colours.
package vga_pkg;

    // 640x480@60 timing
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_CLK_DIV   = 4;

    localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync pulse windows, start inclusive / end exclusive
    localparam int unsigned VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int unsigned VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    // Map window placement
    localparam int unsigned VGA_VIEW_X0     = 270;
    localparam int unsigned VGA_VIEW_Y0     = 190;
    localparam int unsigned VGA_MAP_WIDTH_X = 100;
    localparam int unsigned VGA_MAP_WIDTH_Y = 100;

    // Raster counters are wide enough for totals up to 4096
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned COORD_W = 10;

    // 12-bit RGB (4:4:4) colours for the renderers
    typedef logic [11:0] rgb_t;
    localparam rgb_t RGB_BLACK = 12'h000;
    localparam rgb_t RGB_WHITE = 12'hFFF;
    localparam rgb_t RGB_RED   = 12'hF00;
    localparam rgb_t RGB_GREEN = 12'h0F0;
    localparam rgb_t RGB_BLUE  = 12'h00F;
    localparam rgb_t RGB_GREY  = 12'h888;

    // Camera offset in map units
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cam_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider, h/v raster counters and registered sync/blank decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             pixel_tick_q, pixel_tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_start_q, frame_start_d;
    logic             tick_c;

    // Divider and raster counters; pixel_tick is registered so it lines up with div_cnt
    always_comb begin
        div_cnt_d    = div_cnt_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        tick_c       = (div_cnt_q == DIV_LAST);
        div_cnt_d    = tick_c ? '0 : div_cnt_q + DIV_W'(1);
        if (tick_c) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
        pixel_tick_d = (div_cnt_d == DIV_LAST);
    end

    // Decode of the current counters; registered, so it trails them by one clk
    always_comb begin
        video_on_d    = (h_cnt_q < CNT_W'(H_DISPLAY)) && (v_cnt_q < CNT_W'(V_DISPLAY));
        hsync_d       = !((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END)));
        vsync_d       = !((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END)));
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0) && (div_cnt_q == '0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_tick_q  <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_tick_q  <= pixel_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_tick  = pixel_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;

endmodule

// File: rtl/vga_map_scanner.sv
// VGA raster front end: timing plus screen-to-map translation with a frame-synchronous camera.
module vga_map_scanner
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
    parameter int unsigned VIEW_X0     = VGA_VIEW_X0,
    parameter int unsigned VIEW_Y0     = VGA_VIEW_Y0,
    parameter int unsigned MAP_WIDTH_X = VGA_MAP_WIDTH_X,
    parameter int unsigned MAP_WIDTH_Y = VGA_MAP_WIDTH_Y
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] cam_x,
    input  logic [COORD_W-1:0] cam_y,
    input  logic               cam_valid,
    output logic               pixel_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_start,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    output logic               map_on
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned WIN_X1  = VIEW_X0 + MAP_WIDTH_X;
    localparam int unsigned WIN_Y1  = VIEW_Y0 + MAP_WIDTH_Y;

    localparam logic [CNT_W-1:0]   H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]   V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X0_C    = COORD_W'(VIEW_X0);
    localparam logic [COORD_W-1:0] YTOP_C  = COORD_W'(VIEW_Y0 + MAP_WIDTH_Y - 1);

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    cam_t               cam_in_c;
    cam_t               cam_pend_q, cam_pend_d;
    cam_t               cam_act_q, cam_act_d;
    logic               pend_flag_q, pend_flag_d;
    logic               frame_end_c;
    logic               in_win_c;
    logic [COORD_W-1:0] map_x_q, map_x_d;
    logic [COORD_W-1:0] map_y_q, map_y_d;
    logic               map_on_q, map_on_d;

    vga_timing_gen #(
        .H_DISPLAY (H_DISPLAY),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISPLAY),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CLK_DIV   (CLK_DIV)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_tick  (pixel_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .frame_start (frame_start),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt)
    );

    // Camera double buffer: strobes land in pending, active only moves at the frame boundary
    always_comb begin
        cam_pend_d  = cam_pend_q;
        cam_act_d   = cam_act_q;
        pend_flag_d = pend_flag_q;
        cam_in_c.x  = cam_x;
        cam_in_c.y  = cam_y;
        frame_end_c = pixel_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
        if (cam_valid) begin
            cam_pend_d  = cam_in_c;
            pend_flag_d = 1'b1;
        end
        if (frame_end_c) begin
            if (cam_valid) begin
                cam_act_d = cam_in_c;
            end else if (pend_flag_q) begin
                cam_act_d = cam_pend_q;
            end
            pend_flag_d = 1'b0;
        end
    end

    // Window test and map coordinates; map rows count up from the window's bottom edge
    always_comb begin
        in_win_c = (h_cnt < CNT_W'(H_DISPLAY)) && (v_cnt < CNT_W'(V_DISPLAY)) &&
                   (h_cnt >= CNT_W'(VIEW_X0)) && (h_cnt < CNT_W'(WIN_X1)) &&
                   (v_cnt >= CNT_W'(VIEW_Y0)) && (v_cnt < CNT_W'(WIN_Y1));
        map_on_d = in_win_c;
        map_x_d  = '0;
        map_y_d  = '0;
        if (in_win_c) begin
            map_x_d = COORD_W'(h_cnt) - X0_C + cam_act_q.x;
            map_y_d = YTOP_C - COORD_W'(v_cnt) + cam_act_q.y;
        end
    end

    // Camera and map output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_pend_q  <= '0;
            cam_act_q   <= '0;
            pend_flag_q <= 1'b0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            map_on_q    <= 1'b0;
        end else begin
            cam_pend_q  <= cam_pend_d;
            cam_act_q   <= cam_act_d;
            pend_flag_q <= pend_flag_d;
            map_x_q     <= map_x_d;
            map_y_q     <= map_y_d;
            map_on_q    <= map_on_d;
        end
    end

    assign map_x  = map_x_q;
    assign map_y  = map_y_q;
    assign map_on = map_on_q;

endmodule

// File: tb/tb_vga_map_scanner.sv
// Directed bench on a shrunken raster (28x17 totals) so several frames fit in a short run.
module tb_vga_map_scanner;

    localparam int unsigned HD = 20, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VD = 12, VF = 1, VS = 2, VB = 2;
    localparam int unsigned X0 = 5, Y0 = 3, MWX = 8, MWY = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] cam_x, cam_y;
    logic       cam_valid;

    logic       pixel_tick, hsync, vsync, video_on, frame_start, map_on;
    logic [9:0] map_x, map_y;
    logic       pixel_tick_1, hsync_1, vsync_1, video_on_1, frame_start_1, map_on_1;
    logic [9:0] map_x_1, map_y_1;

    int n_checks = 0;
    int n_fail   = 0;
    int k;

    always #5 clk = ~clk;

    vga_map_scanner #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(4), .VIEW_X0(X0), .VIEW_Y0(Y0), .MAP_WIDTH_X(MWX), .MAP_WIDTH_Y(MWY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cam_x(cam_x), .cam_y(cam_y), .cam_valid(cam_valid),
        .pixel_tick(pixel_tick), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .frame_start(frame_start), .map_x(map_x), .map_y(map_y), .map_on(map_on)
    );

    vga_map_scanner #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(1), .VIEW_X0(X0), .VIEW_Y0(Y0), .MAP_WIDTH_X(MWX), .MAP_WIDTH_Y(MWY)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .cam_x(cam_x), .cam_y(cam_y), .cam_valid(cam_valid),
        .pixel_tick(pixel_tick_1), .hsync(hsync_1), .vsync(vsync_1), .video_on(video_on_1),
        .frame_start(frame_start_1), .map_x(map_x_1), .map_y(map_y_1), .map_on(map_on_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Advance to 1ns after the k-th rising edge since reset release
    task automatic adv(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    // One-clk cam_valid sampled by edge e
    task automatic strobe(input int e, input logic [9:0] x, input logic [9:0] y);
        adv(e - 1);
        cam_x     = x;
        cam_y     = y;
        cam_valid = 1'b1;
        adv(e);
        cam_valid = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
    endtask

    // Edge k shows the decode of pixel p=(k-1)/4 (CLK_DIV=4); frame = 28*17*4 = 1904 clk
    initial begin
        rst_n = 1'b0; cam_valid = 1'b0; cam_x = '0; cam_y = '0; k = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick",   32'(pixel_tick), 0);
        check("rst_hsync",  32'(hsync), 1);
        check("rst_vsync",  32'(vsync), 1);
        check("rst_video",  32'(video_on), 0);
        check("rst_fs",     32'(frame_start), 0);
        check("rst_map_on", 32'(map_on), 0);
        check("rst_map_x",  32'(map_x), 0);
        check("rst_map_y",  32'(map_y), 0);
        check("rst_tick1",  32'(pixel_tick_1), 0);

        release_rst();
        adv(1);
        check("fs_first",    32'(frame_start), 1);
        check("tick_k1",     32'(pixel_tick), 0);
        check("video_00",    32'(video_on), 1);
        check("fs1_first",   32'(frame_start_1), 1);
        check("tick1_k1",    32'(pixel_tick_1), 1);
        adv(2);
        check("fs_width",    32'(frame_start), 0);
        check("tick1_k2",    32'(pixel_tick_1), 1);
        check("fs1_width",   32'(frame_start_1), 0);
        adv(3);   check("tick_k3", 32'(pixel_tick), 1);
        adv(4);   check("tick_k4", 32'(pixel_tick), 0);
        adv(7);   check("tick_k7", 32'(pixel_tick), 1);
        adv(81);  check("video_h20", 32'(video_on), 0);
        adv(88);  check("hsync_h21", 32'(hsync), 1);
        adv(89);  check("hsync_h22", 32'(hsync), 0);
        adv(100); check("hsync_h24", 32'(hsync), 0);
        adv(101); check("hsync_h25", 32'(hsync), 1);

        strobe(200, 10'd5, 10'd1000);

        adv(356); check("win_h4_off", 32'(map_on), 0);
        adv(357);
        check("win_first_on", 32'(map_on), 1);
        check("win_first_x",  32'(map_x), 0);
        check("win_first_y",  32'(map_y), 5);
        adv(476); check("fs1_k476", 32'(frame_start_1), 0);
        adv(477); check("fs1_frame", 32'(frame_start_1), 1);
        adv(945);
        check("win_last_on", 32'(map_on), 1);
        check("win_last_x",  32'(map_x), 7);
        check("win_last_y",  32'(map_y), 0);
        adv(949);
        check("win_past_on", 32'(map_on), 0);
        check("win_past_x",  32'(map_x), 0);
        check("win_past_y",  32'(map_y), 0);
        adv(1309); check("video_last", 32'(video_on), 1);
        adv(1456); check("vsync_v12", 32'(vsync), 1);
        adv(1457); check("vsync_v13", 32'(vsync), 0);
        adv(1680); check("vsync_v14", 32'(vsync), 0);
        adv(1681); check("vsync_v15", 32'(vsync), 1);
        adv(1904); check("fs_k1904", 32'(frame_start), 0);
        adv(1905); check("fs_period", 32'(frame_start), 1);
        adv(2261);
        check("cam1_x", 32'(map_x), 5);
        check("cam1_y", 32'(map_y), 1005);

        strobe(3808, 10'd7, 10'd0);
        adv(4165);
        check("camb_x", 32'(map_x), 7);
        check("camb_y", 32'(map_y), 5);

        strobe(4500, 10'd1, 10'd1);
        strobe(4600, 10'd2, 10'd2);
        adv(4753); check("cam_hold_x", 32'(map_x), 14);
        adv(6069);
        check("cam_last_x", 32'(map_x), 2);
        check("cam_last_y", 32'(map_y), 7);
        adv(6313);
        check("pre_rst_on", 32'(map_on), 1);
        check("pre_rst_x",  32'(map_x), 7);
        check("pre_rst_y",  32'(map_y), 5);

        #1 rst_n = 1'b0;
        #1;
        check("arst_hsync", 32'(hsync), 1);
        check("arst_vsync", 32'(vsync), 1);
        check("arst_on",    32'(map_on), 0);
        check("arst_video", 32'(video_on), 0);
        check("arst_x",     32'(map_x), 0);
        repeat (2) @(negedge clk);
        release_rst();
        adv(1);   check("fs_after_rst", 32'(frame_start), 1);
        adv(357);
        check("cam_rst_x", 32'(map_x), 0);
        check("cam_rst_y", 32'(map_y), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
